// File: rtl/darkaxi_pkg.sv
// Shared AXI4-Lite definitions for the darkaxi responder blocks.
package darkaxi_pkg;

    localparam int unsigned AXI_DW = 32;
    localparam int unsigned AXI_AW = 32;
    localparam int unsigned AXI_SW = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_RESP = 2'b10
    } rd_state_t;

endpackage

// File: rtl/darkaxi_ram_core.sv
// Word-wide block RAM: one byte-enabled write port, one synchronous read-first read port.
module darkaxi_ram_core
    import darkaxi_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [AXI_DW-1:0] wdata_i,
    input  logic [AXI_SW-1:0] wstrb_i,
    input  logic              re_i,
    input  logic [IW-1:0]     raddr_i,
    output logic [AXI_DW-1:0] rdata_o
);

    (* ram_style = "block" *) logic [AXI_DW-1:0] mem_q [DEPTH];
    logic [AXI_DW-1:0] rdata_q;

    // Read and write share one edge; the non-blocking read sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        for (int unsigned b = 0; b < AXI_SW; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/darkaxi_ram_slave.sv
// AXI4-Lite RAM responder: decoupled AW/W holding regs, one-outstanding read FSM,
// programmable read latency and SLVERR for addresses outside the window.
module darkaxi_ram_slave
    import darkaxi_pkg::*;
#(
    parameter int unsigned       DEPTH    = 512,
    parameter logic [AXI_AW-1:0] BASE     = '0,
    parameter int unsigned       READ_LAT = 1
) (
    input  logic              XCLK,
    input  logic              XRES,
    input  logic [AXI_AW-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [AXI_DW-1:0] WDATA,
    input  logic [AXI_SW-1:0] WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [AXI_AW-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [AXI_DW-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY
);

    localparam int unsigned       IW   = $clog2(DEPTH);
    localparam int unsigned       CW   = 5;
    localparam logic [AXI_AW-1:0] SPAN = AXI_AW'(4 * DEPTH);

    // An address below BASE wraps to a huge offset and fails the compare.
    function automatic logic addr_ok(input logic [AXI_AW-1:0] a);
        logic [AXI_AW-1:0] off;
        off = a - BASE;
        return off < SPAN;
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [AXI_AW-1:0] a);
        logic [AXI_AW-1:0] off;
        off = a - BASE;
        return off[IW+1:2];
    endfunction

    logic              aw_full_q, aw_full_d, aw_ok_q, aw_ok_d;
    logic [IW-1:0]     aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [AXI_DW-1:0] wdata_q, wdata_d;
    logic [AXI_SW-1:0] wstrb_q, wstrb_d;
    logic              wr_pend_q, wr_pend_d;
    logic              bvalid_q, bvalid_d;
    resp_t             bresp_q, bresp_d;
    logic              awready_q, wready_q;

    rd_state_t         rd_state_q;
    logic [CW-1:0]     rd_cnt_q;
    logic [IW-1:0]     ar_idx_q;
    logic              ar_ok_q, arready_q, rvalid_q;
    resp_t             rresp_q;
    logic [AXI_DW-1:0] rdata_q, core_rdata;

    // Write channel: a commit is staged one cycle (wr_pend) and lands with BVALID.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_ok_d   = aw_ok_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_pend_d = wr_pend_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_pend_q) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            wr_pend_d = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        end else if (aw_full_q && w_full_q && !bvalid_q) begin
            wr_pend_d = 1'b1;
        end
        if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
        if (AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_ok_d   = addr_ok(AWADDR);
            aw_idx_d  = addr_idx(AWADDR);
        end
        if (WVALID && wready_q) begin
            w_full_d = 1'b1;
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
        end
    end

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            aw_full_q <= 1'b0;
            aw_ok_q   <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_pend_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_ok_q   <= aw_ok_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wr_pend_q <= wr_pend_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
        end
    end

    // Read FSM: counter starts at READ_LAT+1 so the last BRAM sample precedes RVALID by one edge.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            ar_idx_q   <= '0;
            ar_ok_q    <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ARVALID && arready_q) begin
                        ar_idx_q   <= addr_idx(ARADDR);
                        ar_ok_q    <= addr_ok(ARADDR);
                        rd_cnt_q   <= CW'(READ_LAT + 1);
                        arready_q  <= 1'b0;
                        rd_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rd_cnt_q == '0) begin
                        rvalid_q   <= 1'b1;
                        rdata_q    <= ar_ok_q ? core_rdata : '0;
                        rresp_q    <= ar_ok_q ? RESP_OKAY : RESP_SLVERR;
                        rd_state_q <= R_RESP;
                    end else begin
                        rd_cnt_q <= rd_cnt_q - CW'(1);
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    darkaxi_ram_core #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_core (
        .clk_i   (XCLK),
        .we_i    (wr_pend_q && aw_ok_q),
        .waddr_i (aw_idx_q),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .re_i    (rd_state_q == R_WAIT),
        .raddr_i (ar_idx_q),
        .rdata_o (core_rdata)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule
